// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the two cache controllers, the arbiter and
// the backing instruction memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              c0_valid;
  logic [ADDR_W-1:0] c0_addr;
  logic              c0_ready;
  logic [DATA_W-1:0] c0_rdata;
  logic              c1_valid;
  logic [ADDR_W-1:0] c1_addr;
  logic              c1_ready;
  logic [DATA_W-1:0] c1_rdata;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic [DATA_W-1:0] mem_req_rdata;

  // Arbiter side
  modport slave (
    input  c0_valid, c0_addr, c1_valid, c1_addr, mem_req_ready, mem_req_rdata,
    output c0_ready, c0_rdata, c1_ready, c1_rdata, mem_req_valid, mem_req_addr
  );

  // Requester / memory-model side
  modport master (
    output c0_valid, c0_addr, c1_valid, c1_addr, mem_req_ready, mem_req_rdata,
    input  c0_ready, c0_rdata, c1_ready, c1_rdata, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between the compressed
// (port 0) and baseline (port 1) cache controllers, with response timeout.
module mem_port_arbiter #(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(32'h00000013)
) (
  input  logic                clk,
  input  logic                resetn,
  mem_port_arbiter_if.slave   bus,
  output logic                timeout_err,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, BUSY0, BUSY1, RESP0, RESP1} state_t;

  state_t            state, state_n;
  logic              last_grant, last_grant_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic              mem_valid_q, mem_valid_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
  logic              c0_ready_q, c0_ready_n;
  logic [DATA_W-1:0] c0_rdata_q, c0_rdata_n;
  logic              c1_ready_q, c1_ready_n;
  logic [DATA_W-1:0] c1_rdata_q, c1_rdata_n;
  logic              timeout_err_n;
  logic [15:0]       grant_cnt0_n, grant_cnt1_n;
  logic              expired;

  assign expired = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n       = state;
    last_grant_n  = last_grant;
    tcnt_n        = tcnt;
    mem_valid_n   = mem_valid_q;
    mem_addr_n    = mem_addr_q;
    c0_ready_n    = c0_ready_q;
    c0_rdata_n    = c0_rdata_q;
    c1_ready_n    = c1_ready_q;
    c1_rdata_n    = c1_rdata_q;
    timeout_err_n = timeout_err;
    grant_cnt0_n  = grant_cnt0;
    grant_cnt1_n  = grant_cnt1;

    unique case (state)
      IDLE: begin
        // On a tie, last_grant==1 hands the slot to port 0 and vice versa.
        if (bus.c0_valid && (!bus.c1_valid || last_grant)) begin
          state_n      = BUSY0;
          mem_valid_n  = 1'b1;
          mem_addr_n   = bus.c0_addr;
          last_grant_n = 1'b0;
          tcnt_n       = '0;
          if (grant_cnt0 != '1) grant_cnt0_n = grant_cnt0 + 16'd1;
        end else if (bus.c1_valid) begin
          state_n      = BUSY1;
          mem_valid_n  = 1'b1;
          mem_addr_n   = bus.c1_addr;
          last_grant_n = 1'b1;
          tcnt_n       = '0;
          if (grant_cnt1 != '1) grant_cnt1_n = grant_cnt1 + 16'd1;
        end
      end
      BUSY0, BUSY1: begin
        // A response arriving on the expiry cycle takes priority over the abort.
        if (bus.mem_req_ready || expired) begin
          mem_valid_n = 1'b0;
          if (!bus.mem_req_ready) timeout_err_n = 1'b1;
          if (state == BUSY1) begin
            state_n    = RESP1;
            c1_ready_n = 1'b1;
            c1_rdata_n = bus.mem_req_ready ? bus.mem_req_rdata : ERR_DATA;
          end else begin
            state_n    = RESP0;
            c0_ready_n = 1'b1;
            c0_rdata_n = bus.mem_req_ready ? bus.mem_req_rdata : ERR_DATA;
          end
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      RESP0: begin
        c0_ready_n = 1'b0;
        state_n    = IDLE;
      end
      RESP1: begin
        c1_ready_n = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      tcnt        <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      c0_ready_q  <= 1'b0;
      c0_rdata_q  <= '0;
      c1_ready_q  <= 1'b0;
      c1_rdata_q  <= '0;
      timeout_err <= 1'b0;
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      tcnt        <= tcnt_n;
      mem_valid_q <= mem_valid_n;
      mem_addr_q  <= mem_addr_n;
      c0_ready_q  <= c0_ready_n;
      c0_rdata_q  <= c0_rdata_n;
      c1_ready_q  <= c1_ready_n;
      c1_rdata_q  <= c1_rdata_n;
      timeout_err <= timeout_err_n;
      grant_cnt0  <= grant_cnt0_n;
      grant_cnt1  <= grant_cnt1_n;
    end
  end

  assign bus.mem_req_valid = mem_valid_q;
  assign bus.mem_req_addr  = mem_addr_q;
  assign bus.c0_ready      = c0_ready_q;
  assign bus.c0_rdata      = c0_rdata_q;
  assign bus.c1_ready      = c1_ready_q;
  assign bus.c1_rdata      = c1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for arbitration/data paths,
// hand-written sequences for timeout, stray ready and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        timeout_err;
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4),
    .ERR_DATA(32'h00000013)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .timeout_err(timeout_err),
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers after mem_lat BUSY cycles, data = mem_base + addr.
  logic [7:0]  mem_cnt;
  logic [7:0]  mem_lat;
  logic [31:0] mem_base;
  logic        mem_en;
  logic        mem_stray;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) mem_cnt <= 8'd0;
    else if (bus.mem_req_valid && !bus.mem_req_ready) mem_cnt <= mem_cnt + 8'd1;
    else mem_cnt <= 8'd0;
  end

  assign bus.mem_req_ready = (bus.mem_req_valid && mem_en && (mem_cnt == mem_lat)) || mem_stray;
  assign bus.mem_req_rdata = mem_base + bus.mem_req_addr;

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic        v1;
    logic [31:0] a1;
    logic [7:0]  lat;
    logic [31:0] base;
    int          eport;
    logic [31:0] eaddr;
    logic [31:0] edata;
    int          ecyc;
  } vec_t;

  vec_t        vecs [11];
  vec_t        v_after_rst;
  vec_t        v_post_to;
  logic [31:0] last_rd [2];
  int          n_cmp;
  int          n_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one transaction from IDLE and checks the served port, address, data,
  // latency, the untouched port's rdata, and that ready is a single pulse.
  task automatic apply(input vec_t v, input string tag);
    int          cyc;
    logic [31:0] maddr;
    logic        got;
    mem_lat        = v.lat;
    mem_base       = v.base;
    bus.c0_valid   = v.v0;
    bus.c0_addr    = v.a0;
    bus.c1_valid   = v.v1;
    bus.c1_addr    = v.a1;
    cyc   = 0;
    got   = 1'b0;
    maddr = '0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (bus.mem_req_valid) maddr = bus.mem_req_addr;
      if (bus.c0_ready || bus.c1_ready) got = 1'b1;
    end
    bus.c0_valid = 1'b0;
    bus.c1_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_ready: got no ready within 40 cycles, expected port %0d", tag, v.eport);
    end else begin
      chk({tag, "_port"}, bus.c1_ready ? 32'd1 : 32'd0, 32'(v.eport));
      chk({tag, "_both_ready"}, 32'(bus.c0_ready & bus.c1_ready), 32'd0);
      chk({tag, "_cycles"}, 32'(cyc), 32'(v.ecyc));
      chk({tag, "_mem_addr"}, maddr, v.eaddr);
      chk({tag, "_rdata"}, (v.eport == 1) ? bus.c1_rdata : bus.c0_rdata, v.edata);
      chk({tag, "_other_rdata"}, (v.eport == 1) ? bus.c0_rdata : bus.c1_rdata,
          last_rd[1 - v.eport]);
      last_rd[v.eport] = v.edata;
    end
    tick();
    chk({tag, "_pulse_once"}, 32'(bus.c0_ready | bus.c1_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cyc;
    logic got;
    n_cmp = 0;
    n_bad = 0;
    last_rd[0] = '0;
    last_rd[1] = '0;

    //        v0    a0        v1    a1        lat   base          port addr      data          cyc
    vecs[0]  = '{1'b1, 32'h10,  1'b1, 32'h20,  8'd0, 32'h1000,     0, 32'h10,  32'h1010,     2};
    vecs[1]  = '{1'b0, 32'h10,  1'b1, 32'h20,  8'd0, 32'h1000,     1, 32'h20,  32'h1020,     2};
    vecs[2]  = '{1'b1, 32'h100, 1'b1, 32'h200, 8'd0, 32'h0,        0, 32'h100, 32'h100,      2};
    vecs[3]  = '{1'b1, 32'h104, 1'b1, 32'h204, 8'd1, 32'h0,        1, 32'h204, 32'h204,      3};
    vecs[4]  = '{1'b1, 32'h108, 1'b1, 32'h208, 8'd0, 32'h0,        0, 32'h108, 32'h108,      2};
    vecs[5]  = '{1'b1, 32'h10c, 1'b1, 32'h20c, 8'd2, 32'h0,        1, 32'h20c, 32'h20c,      4};
    vecs[6]  = '{1'b1, 32'h110, 1'b1, 32'h210, 8'd0, 32'h0,        0, 32'h110, 32'h110,      2};
    vecs[7]  = '{1'b1, 32'h114, 1'b1, 32'h214, 8'd0, 32'h0,        1, 32'h214, 32'h214,      2};
    vecs[8]  = '{1'b1, 32'h0,   1'b0, 32'h0,   8'd0, 32'h2202,     0, 32'h0,   32'h2202,     2};
    vecs[9]  = '{1'b1, 32'h40,  1'b0, 32'h0,   8'd3, 32'hDEADBEAF, 0, 32'h40,  32'hDEADBEEF, 5};
    vecs[10] = '{1'b0, 32'h0,   1'b1, 32'h80,  8'd3, 32'h12340000, 1, 32'h80,  32'h12340080, 5};
    v_post_to   = '{1'b0, 32'h0,   1'b1, 32'h90,  8'd1, 32'h0, 1, 32'h90,  32'h90,  3};
    v_after_rst = '{1'b1, 32'h500, 1'b1, 32'h600, 8'd0, 32'h0, 0, 32'h500, 32'h500, 2};

    resetn       = 1'b0;
    bus.c0_valid = 1'b0;
    bus.c0_addr  = '0;
    bus.c1_valid = 1'b0;
    bus.c1_addr  = '0;
    mem_lat      = 8'd0;
    mem_base     = '0;
    mem_en       = 1'b1;
    mem_stray    = 1'b0;
    tick();
    tick();
    chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
    chk("rst_c0_ready", 32'(bus.c0_ready), 32'd0);
    chk("rst_c1_ready", 32'(bus.c1_ready), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_grant_cnt0", 32'(grant_cnt0), 32'd0);
    resetn = 1'b1;
    tick();

    // Tie after reset, strict alternation under continuous load, single-port, late responses
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
      if (i == 1) begin
        chk("t2_grant_cnt0", 32'(grant_cnt0), 32'd1);
        chk("t2_grant_cnt1", 32'(grant_cnt1), 32'd1);
      end
      if (i == 9) chk("resp_on_expiry_no_err", 32'(timeout_err), 32'd0);
    end
    chk("grant_cnt0_after_table", 32'(grant_cnt0), 32'd6);
    chk("grant_cnt1_after_table", 32'(grant_cnt1), 32'd5);

    // mem_req_ready outside BUSY must be ignored
    mem_stray = 1'b1;
    tick();
    tick();
    tick();
    chk("stray_c0_ready", 32'(bus.c0_ready), 32'd0);
    chk("stray_c1_ready", 32'(bus.c1_ready), 32'd0);
    chk("stray_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("stray_c0_rdata", bus.c0_rdata, last_rd[0]);
    chk("stray_c1_rdata", bus.c1_rdata, last_rd[1]);
    mem_stray = 1'b0;
    tick();

    // Timeout: 4 BUSY cycles after the grant edge, then RESP with the NOP fill
    mem_en       = 1'b0;
    bus.c0_valid = 1'b1;
    bus.c0_addr  = 32'h44;
    tick();
    chk("to_grant_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("to_grant_addr", bus.mem_req_addr, 32'h44);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (bus.c0_ready) got = 1'b1;
    end
    bus.c0_valid = 1'b0;
    chk("to_ready_seen", 32'(got), 32'd1);
    chk("to_cycles_after_grant", 32'(cyc), 32'd4);
    chk("to_c0_rdata", bus.c0_rdata, 32'h00000013);
    chk("to_timeout_err", 32'(timeout_err), 32'd1);
    chk("to_mem_req_valid_dropped", 32'(bus.mem_req_valid), 32'd0);
    chk("to_c1_ready", 32'(bus.c1_ready), 32'd0);
    last_rd[0] = 32'h00000013;
    tick();
    chk("to_pulse_once", 32'(bus.c0_ready), 32'd0);
    mem_en = 1'b1;
    tick();
    tick();
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    apply(v_post_to, "post_to");
    chk("to_err_sticky_after_txn", 32'(timeout_err), 32'd1);
    chk("grant_cnt0_after_to", 32'(grant_cnt0), 32'd7);

    // Reset while BUSY1: outputs clear at once, no ready pulse afterwards
    mem_en       = 1'b0;
    bus.c1_valid = 1'b1;
    bus.c1_addr  = 32'h300;
    tick();
    chk("mr_grant_valid", 32'(bus.mem_req_valid), 32'd1);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("mr_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("mr_mem_req_addr", bus.mem_req_addr, 32'd0);
    chk("mr_c0_rdata", bus.c0_rdata, 32'd0);
    chk("mr_c1_rdata", bus.c1_rdata, 32'd0);
    chk("mr_c1_ready", 32'(bus.c1_ready), 32'd0);
    chk("mr_timeout_err", 32'(timeout_err), 32'd0);
    chk("mr_grant_cnt1", 32'(grant_cnt1), 32'd0);
    bus.c1_valid = 1'b0;
    tick();
    tick();
    chk("mr_no_c1_pulse", 32'(bus.c1_ready), 32'd0);
    resetn     = 1'b1;
    mem_en     = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    tick();
    apply(v_after_rst, "after_rst_tie");
    chk("after_rst_grant_cnt0", 32'(grant_cnt0), 32'd1);
    chk("after_rst_grant_cnt1", 32'(grant_cnt1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
